// File: rtl/char_scroll_ctrl_if.sv
// char_scroll_ctrl_if
//   Bundles the host message-write/control port and the glyph ROM port of
//   the scroll controller.
//   Signals
//     wr_en, wr_addr, wr_data : message buffer write port (host -> ctrl)
//     msg_len                 : active message length, sampled on start
//     start, stop             : control pulses (host -> ctrl)
//     rom_cs, rom_char,
//     rom_column              : glyph ROM request (ctrl -> ROM)
//     rom_data                : glyph ROM column data, combinational (ROM -> ctrl)
//   Modports
//     slave  : the scroll controller
//     master : host + ROM side (testbench / SoC glue)
interface char_scroll_ctrl_if #(
    parameter int MSG_DEPTH = 32
);
    localparam int AW = $clog2(MSG_DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   msg_len;
    logic          start;
    logic          stop;
    logic          rom_cs;
    logic [7:0]    rom_char;
    logic [1:0]    rom_column;
    logic [15:0]   rom_data;

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, stop, rom_data,
        output rom_cs, rom_char, rom_column
    );

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, stop, rom_data,
        input  rom_cs, rom_char, rom_column
    );
endinterface

// File: rtl/char_scroll_ctrl.sv
// char_scroll_ctrl
//   Scrolls a host-written text message across an LED column display.
//   Every TICK_DIV+1 clocks one display column is produced: either a glyph
//   column fetched from the 4-column character ROM or a blank gap column
//   after each character, and shifted into the frame register at col 0.
//   Ports
//     clk, rst_n : clock (rising edge), async active-low reset
//     bus        : host write/control + glyph ROM port (slave modport)
//     frame      : DISP_COLS columns x 10 bits, col 0 = [9:0] = newest
//     busy       : high while not IDLE
//     step       : 1-cycle pulse coincident with each frame update
//     wrap       : 1-cycle pulse with step when the last char's gap shifts in
module char_scroll_ctrl #(
    parameter int MSG_DEPTH = 32,
    parameter int TICK_DIV  = 4,
    parameter int DISP_COLS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    char_scroll_ctrl_if.slave        bus,
    output logic [DISP_COLS*10-1:0]  frame,
    output logic                     busy,
    output logic                     step,
    output logic                     wrap
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int FW = DISP_COLS * 10;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    msg_buf [MSG_DEPTH];
    logic [AW-1:0] char_idx;
    logic [2:0]    col_idx;
    logic [TW-1:0] tick;
    logic [AW:0]   len_q;

    logic [7:0]    cur_char;
    logic          glyph_ok;
    logic          launch;
    logic          do_shift;
    logic          tick_last;
    logic          last_char;
    logic [9:0]    shift_col;
    logic          rom_cs_c;
    logic [7:0]    rom_char_c;
    logic [1:0]    rom_column_c;
    logic          rom_hi_unused;

    // Buffer read is combinational from the registered index, so a write
    // landing on the same entry during FETCH only takes effect afterwards:
    // the fetch sees the old character.
    assign cur_char  = msg_buf[char_idx];
    // Column 4 is the inter-character gap; codes >= 128 have no glyph.
    assign glyph_ok  = (col_idx != 3'd4) && !cur_char[7];
    // stop dominates start, and start only counts from IDLE with a
    // non-empty message.
    assign launch    = (state_q == IDLE) && bus.start && !bus.stop &&
                       (bus.msg_len != '0);
    // A FETCH cut short by stop leaves frame and indices untouched.
    assign do_shift  = (state_q == FETCH) && !bus.stop;
    assign tick_last = (tick == TW'(TICK_DIV - 1));
    assign last_char = ({1'b0, char_idx} == (len_q - 1'b1));
    assign shift_col = glyph_ok ? bus.rom_data[9:0] : 10'd0;
    assign busy      = (state_q != IDLE);

    // Upper ROM bits are not part of the glyph.
    assign rom_hi_unused = ^bus.rom_data[15:10];

    assign bus.rom_cs     = rom_cs_c;
    assign bus.rom_char   = rom_char_c;
    assign bus.rom_column = rom_column_c;

    // Message buffer: write port only, deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) msg_buf[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rom_cs_c     = 1'b0;
        rom_char_c   = 8'd0;
        rom_column_c = 2'd0;

        case (state_q)
            IDLE:    if (launch) state_d = WAIT;
            WAIT:    if (tick_last) state_d = FETCH;
            FETCH:   state_d = WAIT;
            default: state_d = IDLE;
        endcase

        if (bus.stop) state_d = IDLE;

        if ((state_q == FETCH) && glyph_ok) begin
            rom_cs_c     = 1'b1;
            rom_char_c   = cur_char;
            rom_column_c = col_idx[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            char_idx <= '0;
            col_idx  <= '0;
            tick     <= '0;
            len_q    <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;

            if (launch) begin
                frame    <= '0;
                char_idx <= '0;
                col_idx  <= '0;
                tick     <= '0;
                len_q    <= (bus.msg_len > (AW+1)'(MSG_DEPTH)) ?
                            (AW+1)'(MSG_DEPTH) : bus.msg_len;
            end

            if ((state_q == WAIT) && !bus.stop) begin
                tick <= tick_last ? '0 : tick + 1'b1;
            end

            if (do_shift) begin
                frame <= {frame[FW-11:0], shift_col};
                step  <= 1'b1;
                if (col_idx == 3'd4) begin
                    col_idx <= '0;
                    if (last_char) begin
                        char_idx <= '0;
                        wrap     <= 1'b1;
                    end else begin
                        char_idx <= char_idx + 1'b1;
                    end
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_char_scroll_ctrl.sv
module tb_char_scroll_ctrl;
    localparam int MSG_DEPTH = 32;
    localparam int TICK_DIV  = 4;
    localparam int DISP_COLS = 16;
    localparam int FW        = DISP_COLS * 10;

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] frame;
    logic          busy, step, wrap;

    char_scroll_ctrl_if #(.MSG_DEPTH(MSG_DEPTH)) bus ();

    char_scroll_ctrl #(
        .MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV), .DISP_COLS(DISP_COLS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .frame(frame), .busy(busy), .step(step), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM model: A, B, C hand-defined; upper bits set to junk so the
    // bench notices if anything above bit 9 leaks into the frame.
    function automatic logic [15:0] glyph(input logic [7:0] c, input logic [1:0] col);
        logic [9:0] g;
        case (c)
            8'h41: case (col) 2'd0: g = 10'h3FE; 2'd1: g = 10'h011; 2'd2: g = 10'h011; default: g = 10'h3FE; endcase
            8'h42: case (col) 2'd0: g = 10'h3FF; 2'd1: g = 10'h221; 2'd2: g = 10'h221; default: g = 10'h1DE; endcase
            8'h43: case (col) 2'd0: g = 10'h1FE; 2'd1: g = 10'h201; 2'd2: g = 10'h201; default: g = 10'h102; endcase
            default: g = {c, col};
        endcase
        return {6'b101101, g};
    endfunction

    assign bus.rom_data = glyph(bus.rom_char, bus.rom_column);

    typedef struct {
        logic [9:0] col;
        logic       wrap;
        logic       cs;
        logic [7:0] ch;
        logic [1:0] cidx;
    } vec_t;

    vec_t          vt [11];
    int            n_total = 0;
    int            n_pass  = 0;
    logic [FW-1:0] mframe;
    logic [FW-1:0] fsave;

    task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Advance to the next step pulse; returns the cycles taken and the ROM
    // request seen in the cycle just before (the FETCH cycle).
    task automatic wait_step(output int cyc, output logic cs, output logic [7:0] ch,
                             output logic [1:0] col);
        cyc = 0;
        do begin
            cs = bus.rom_cs; ch = bus.rom_char; col = bus.rom_column;
            tick();
            cyc++;
        end while (!step && cyc < 60);
        chk("step_seen", step, 1'b1);
    endtask

    task automatic step_exp(input string nm, input logic [9:0] e);
        int c; logic cs; logic [7:0] ch; logic [1:0] col;
        wait_step(c, cs, ch, col);
        mframe = {mframe[FW-11:0], e};
        chk(nm, frame, mframe);
    endtask

    task automatic wait_cs();
        int n = 0;
        while (!bus.rom_cs && n < 40) begin
            tick();
            n++;
        end
        chk("fetch_found", bus.rom_cs, 1'b1);
    endtask

    initial begin
        int c; logic cs; logic [7:0] ch; logic [1:0] col; logic saw;

        vt[0]  = '{10'h3FE, 1'b0, 1'b1, 8'h41, 2'd0};
        vt[1]  = '{10'h011, 1'b0, 1'b1, 8'h41, 2'd1};
        vt[2]  = '{10'h011, 1'b0, 1'b1, 8'h41, 2'd2};
        vt[3]  = '{10'h3FE, 1'b0, 1'b1, 8'h41, 2'd3};
        vt[4]  = '{10'h000, 1'b0, 1'b0, 8'h00, 2'd0};
        vt[5]  = '{10'h3FF, 1'b0, 1'b1, 8'h42, 2'd0};
        vt[6]  = '{10'h221, 1'b0, 1'b1, 8'h42, 2'd1};
        vt[7]  = '{10'h221, 1'b0, 1'b1, 8'h42, 2'd2};
        vt[8]  = '{10'h1DE, 1'b0, 1'b1, 8'h42, 2'd3};
        vt[9]  = '{10'h000, 1'b1, 1'b0, 8'h00, 2'd0};
        vt[10] = '{10'h3FE, 1'b0, 1'b1, 8'h41, 2'd0};

        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.msg_len = '0; bus.start = 1'b0; bus.stop = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame", frame, '0);
        chk("rst_step", step, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_rom_cs", bus.rom_cs, 1'b0);
        rst_n = 1'b1;
        tick();

        // "AB" scroll through one full wrap
        wr(5'd0, 8'h41);
        wr(5'd1, 8'h42);
        bus.msg_len = 6'd2;
        start_pulse();
        chk("start_busy", busy, 1'b1);
        mframe = '0;
        for (int i = 0; i < 11; i++) begin
            wait_step(c, cs, ch, col);
            mframe = {mframe[FW-11:0], vt[i].col};
            chk($sformatf("period%0d", i), c, 5);
            chk($sformatf("frame%0d", i), frame, mframe);
            chk($sformatf("wrap%0d", i), wrap, vt[i].wrap);
            chk($sformatf("rom_cs%0d", i), cs, vt[i].cs);
            if (vt[i].cs) begin
                chk($sformatf("rom_char%0d", i), ch, vt[i].ch);
                chk($sformatf("rom_col%0d", i), col, vt[i].cidx);
            end
        end

        // stop during FETCH: no shift, back to IDLE, frame holds
        wait_cs();
        fsave = frame;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_noshift", frame, fsave);
        chk("stop_nostep", step, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("stop_hold", frame, fsave);
        chk("stop_idle", busy, 1'b0);

        // start+stop together from IDLE: stop wins, frame not cleared
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("ss_busy", busy, 1'b0);
        chk("ss_frame", frame, fsave);

        // msg_len == 0 start ignored
        bus.msg_len = 6'd0;
        start_pulse();
        chk("len0_busy", busy, 1'b0);
        tick();
        chk("len0_busy2", busy, 1'b0);
        chk("len0_frame", frame, fsave);

        // char >= 128: no ROM access, zero columns, wrap after gap
        wr(5'd0, 8'hC1);
        bus.msg_len = 6'd1;
        start_pulse();
        chk("hi_busy", busy, 1'b1);
        chk("hi_clear", frame, '0);
        for (int k = 0; k < 5; k++) begin
            wait_step(c, cs, ch, col);
            chk($sformatf("hi_cs%0d", k), cs, 1'b0);
            chk($sformatf("hi_frame%0d", k), frame, '0);
            chk($sformatf("hi_wrap%0d", k), wrap, (k == 4));
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // live rewrite of buffer[1] while 'A' scrolls
        wr(5'd0, 8'h41);
        wr(5'd1, 8'h42);
        bus.msg_len = 6'd2;
        start_pulse();
        mframe = '0;
        step_exp("rw_a0", 10'h3FE);
        step_exp("rw_a1", 10'h011);
        wr(5'd1, 8'h43);
        step_exp("rw_a2", 10'h011);
        step_exp("rw_a3", 10'h3FE);
        step_exp("rw_gap", 10'h000);
        step_exp("rw_c0", 10'h1FE);

        // write to the entry being fetched: fetch uses the old char
        wait_cs();
        chk("col_char", bus.rom_char, 8'h43);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        chk("col_step", step, 1'b1);
        mframe = {mframe[FW-11:0], 10'h201};
        chk("col_old", frame, mframe);
        step_exp("col_new", 10'h011);

        // async reset in the middle of a FETCH
        wait_cs();
        rst_n = 1'b0;
        #1;
        chk("arst_cs", bus.rom_cs, 1'b0);
        chk("arst_frame", frame, '0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step) saw = 1'b1;
        end
        chk("arst_nostep", saw, 1'b0);
        chk("arst_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
